// File: rtl/wb_stage.sv
// MIPS write-back stage: 2-entry in-order skid FIFO between MEM and the register file,
// with load byte/half extraction at enqueue, r0 write suppression, head forwarding and a retire counter.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regwrite,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              in_mem_to_reg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_rdata,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic              wb_stall,
  output logic              regwrite,
  output logic [REG_AW-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_count
);

  // Little-endian load lane select; only meaningful for a 32-bit datapath.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] rdata,
    input logic [1:0]        addr,
    input logic [1:0]        size,
    input logic              uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (addr)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   load_extract = uns ? {{(DATA_W-8){1'b0}}, b} : {{(DATA_W-8){b[7]}}, b};
      2'b01:   load_extract = uns ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
      default: load_extract = rdata;
    endcase
  endfunction

  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        ent_we_q, ent_we_d;
  logic [REG_AW-1:0] ent_dest_q [2];
  logic [REG_AW-1:0] ent_dest_d [2];
  logic [DATA_W-1:0] ent_data_q [2];
  logic [DATA_W-1:0] ent_data_d [2];
  logic [CNT_W-1:0]  retire_count_q, retire_count_d;

  logic              empty_s;
  logic              accept_s;
  logic              retire_s;
  logic              in_we_s;
  logic [DATA_W-1:0] in_data_s;

  // Handshake, retire decision and final data formed on the way in.
  always_comb begin
    empty_s   = (count_q == 2'd0);
    in_ready  = (count_q != 2'd2);
    accept_s  = in_valid & in_ready;
    retire_s  = ~empty_s & ~wb_stall;
    in_we_s   = in_regwrite & (in_dest != {REG_AW{1'b0}});
    in_data_s = in_mem_to_reg ? load_extract(in_mem_rdata, in_alu_result[1:0], in_size, in_unsigned)
                              : in_alu_result;
  end

  // Next-state for pointers, occupancy, storage and retire counter.
  always_comb begin
    ent_we_d   = ent_we_q;
    ent_dest_d = ent_dest_q;
    ent_data_d = ent_data_q;
    if (accept_s) begin
      ent_we_d[wr_ptr_q]   = in_we_s;
      ent_dest_d[wr_ptr_q] = in_dest;
      ent_data_d[wr_ptr_q] = in_data_s;
      wr_ptr_d             = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (retire_s) begin
      rd_ptr_d       = ~rd_ptr_q;
      retire_count_d = retire_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d       = rd_ptr_q;
      retire_count_d = retire_count_q;
    end
    case ({accept_s, retire_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Register-file and forwarding view of the head; zeros while empty.
  always_comb begin
    if (empty_s) begin
      regwrite   = 1'b0;
      write_reg  = {REG_AW{1'b0}};
      write_data = {DATA_W{1'b0}};
      fwd_valid  = 1'b0;
    end else begin
      regwrite   = retire_s & ent_we_q[rd_ptr_q];
      write_reg  = ent_dest_q[rd_ptr_q];
      write_data = ent_data_q[rd_ptr_q];
      fwd_valid  = ent_we_q[rd_ptr_q];
    end
    fwd_reg      = write_reg;
    fwd_data     = write_data;
    retire_count = retire_count_q;
  end

  // State registers; reset drops every buffered entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q        <= 2'd0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      ent_we_q       <= 2'b00;
      ent_dest_q[0]  <= {REG_AW{1'b0}};
      ent_dest_q[1]  <= {REG_AW{1'b0}};
      ent_data_q[0]  <= {DATA_W{1'b0}};
      ent_data_q[1]  <= {DATA_W{1'b0}};
      retire_count_q <= {CNT_W{1'b0}};
    end else begin
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      ent_we_q       <= ent_we_d;
      ent_dest_q     <= ent_dest_d;
      ent_data_q     <= ent_data_d;
      retire_count_q <= retire_count_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/load paths, r0, backpressure, streaming and async reset.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwrite;
  logic [4:0]  in_dest;
  logic        in_mem_to_reg;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_rdata;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic        wb_stall;
  logic        regwrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic [31:0] retire_count;

  int n_checks = 0;
  int n_fail   = 0;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_regwrite(in_regwrite), .in_dest(in_dest), .in_mem_to_reg(in_mem_to_reg),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
    .in_size(in_size), .in_unsigned(in_unsigned),
    .wb_stall(wb_stall),
    .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("check %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction at the falling edge, then sample 1 ns after the next rising edge.
  task automatic push(input logic rw, input logic [4:0] dest, input logic m2r,
                      input logic [31:0] alu, input logic [31:0] rdata,
                      input logic [1:0] size, input logic uns);
    @(negedge clk);
    in_valid      = 1'b1;
    in_regwrite   = rw;
    in_dest       = dest;
    in_mem_to_reg = m2r;
    in_alu_result = alu;
    in_mem_rdata  = rdata;
    in_size       = size;
    in_unsigned   = uns;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load_case(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] exp);
    push(1'b1, 5'd3, 1'b1, addr, 32'h80FF7F01, size, uns);
    check({tag, "_regwrite"}, 32'(regwrite), 32'd1);
    check({tag, "_data"}, write_data, exp);
    idle_cycle();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_regwrite = 1'b0; in_dest = 5'd0; in_mem_to_reg = 1'b0;
    in_alu_result = 32'd0; in_mem_rdata = 32'd0; in_size = 2'b10; in_unsigned = 1'b0; wb_stall = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_regwrite", 32'(regwrite), 32'd0);
    check("rst_write_reg", 32'(write_reg), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    check("rst_count", retire_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ALU path
    push(1'b1, 5'd5, 1'b0, 32'h12345678, 32'h0, 2'b10, 1'b0);
    check("alu_regwrite", 32'(regwrite), 32'd1);
    check("alu_write_reg", 32'(write_reg), 32'd5);
    check("alu_write_data", write_data, 32'h12345678);
    check("alu_fwd_valid", 32'(fwd_valid), 32'd1);
    check("alu_fwd_data", fwd_data, 32'h12345678);
    idle_cycle();
    check("alu_count", retire_count, 32'd1);
    check("alu_empty_regwrite", 32'(regwrite), 32'd0);

    // Loads from 0x80FF7F01
    load_case("lb_a2_s", 32'd2, 2'b00, 1'b0, 32'hFFFFFFFF);
    load_case("lbu_a2", 32'd2, 2'b00, 1'b1, 32'h000000FF);
    load_case("lb_a0_s", 32'd0, 2'b00, 1'b0, 32'h00000001);
    load_case("lh_a2_s", 32'd2, 2'b01, 1'b0, 32'hFFFF80FF);
    load_case("lhu_a1", 32'd1, 2'b01, 1'b1, 32'h00007F01);
    load_case("lw", 32'd0, 2'b10, 1'b0, 32'h80FF7F01);
    load_case("lw_sz3", 32'd3, 2'b11, 1'b1, 32'h80FF7F01);
    check("load_count", retire_count, 32'd8);

    // Register 0
    push(1'b1, 5'd0, 1'b0, 32'hDEADBEEF, 32'h0, 2'b10, 1'b0);
    check("r0_regwrite", 32'(regwrite), 32'd0);
    check("r0_fwd_valid", 32'(fwd_valid), 32'd0);
    idle_cycle();
    check("r0_count", retire_count, 32'd9);

    // Backpressure: A, B fill the FIFO, C is held by the source
    @(negedge clk);
    wb_stall = 1'b1;
    push(1'b1, 5'd10, 1'b0, 32'hA0A0A0A0, 32'h0, 2'b10, 1'b0);
    check("bp_a_regwrite", 32'(regwrite), 32'd0);
    check("bp_a_ready", 32'(in_ready), 32'd1);
    check("bp_a_fwd_valid", 32'(fwd_valid), 32'd1);
    check("bp_a_fwd_reg", 32'(fwd_reg), 32'd10);
    push(1'b1, 5'd11, 1'b0, 32'hB0B0B0B0, 32'h0, 2'b10, 1'b0);
    check("bp_b_ready", 32'(in_ready), 32'd0);
    push(1'b1, 5'd12, 1'b0, 32'hC0C0C0C0, 32'h0, 2'b10, 1'b0);
    check("bp_c_ready", 32'(in_ready), 32'd0);
    check("bp_c_fwd_reg", 32'(fwd_reg), 32'd10);
    check("bp_c_count", retire_count, 32'd9);
    @(negedge clk);
    wb_stall = 1'b0;
    #1;
    check("bp_w1_regwrite", 32'(regwrite), 32'd1);
    check("bp_w1_reg", 32'(write_reg), 32'd10);
    check("bp_w1_data", write_data, 32'hA0A0A0A0);
    @(posedge clk);
    #1;
    check("bp_w2_regwrite", 32'(regwrite), 32'd1);
    check("bp_w2_reg", 32'(write_reg), 32'd11);
    check("bp_w2_data", write_data, 32'hB0B0B0B0);
    @(posedge clk);
    #1;
    check("bp_w3_regwrite", 32'(regwrite), 32'd1);
    check("bp_w3_reg", 32'(write_reg), 32'd12);
    check("bp_w3_data", write_data, 32'hC0C0C0C0);
    idle_cycle();
    check("bp_count", retire_count, 32'd12);
    check("bp_empty_regwrite", 32'(regwrite), 32'd0);

    // Streaming: one accept and one write per cycle
    for (int i = 1; i <= 8; i++) begin
      push(1'b1, 5'(i), 1'b0, 32'h100 + 32'(i), 32'h0, 2'b10, 1'b0);
      check($sformatf("st%0d_ready", i), 32'(in_ready), 32'd1);
      check($sformatf("st%0d_regwrite", i), 32'(regwrite), 32'd1);
      check($sformatf("st%0d_reg", i), 32'(write_reg), 32'(i));
      check($sformatf("st%0d_data", i), write_data, 32'h100 + 32'(i));
    end
    idle_cycle();
    check("st_count", retire_count, 32'd20);

    // Reset mid-operation with two buffered entries
    @(negedge clk);
    wb_stall = 1'b1;
    push(1'b1, 5'd20, 1'b0, 32'h20202020, 32'h0, 2'b10, 1'b0);
    push(1'b1, 5'd21, 1'b0, 32'h21212121, 32'h0, 2'b10, 1'b0);
    check("mr_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mr_regwrite", 32'(regwrite), 32'd0);
    check("mr_ready", 32'(in_ready), 32'd1);
    check("mr_count", retire_count, 32'd0);
    check("mr_fwd_valid", 32'(fwd_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wb_stall = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("mr_post%0d_regwrite", c), 32'(regwrite), 32'd0);
      check($sformatf("mr_post%0d_count", c), retire_count, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
